// File: rtl/gf2_poly_divider.sv
// -----------------------------------------------------------------------------
// gf2_poly_divider
//
// Sequential long division of a 2N-bit polynomial by an N-bit polynomial over
// GF(2). One quotient bit is produced per clock.
//
// The divisor is first normalised, i.e. shifted left until its top coefficient
// is set. This turns "is the working remainder at least as big as the divisor"
// into a single-bit test. Dividing a*x^sh by b*x^sh gives the same quotient as
// a/b. The remainder comes out scaled by x^sh, so it is shifted back right by
// sh places at the end.
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      synchronous active-high reset, aborts any running division
//   start_i  division request, only looked at while idle
//   a_i      dividend, 2N bits, bit i = coefficient of x^i
//   b_i      divisor, N bits
//   busy_o   high whenever the unit is not idle (including the done cycle)
//   done_o   one-cycle pulse when q_o / r_o / err_o carry a new result
//   err_o    divide-by-zero flag, valid together with done_o
//   q_o      quotient a div b (2N bits)
//   r_o      remainder a mod b (N-1 bits)
// -----------------------------------------------------------------------------
module gf2_poly_divider #(
    parameter int N = 571
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2*N-1:0]   a_i,
    input  logic [N-1:0]     b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2*N-1:0]   q_o,
    output logic [N-2:0]     r_o
);

    localparam int W2  = 2 * N;
    // The step counter has to reach 2N+sh-1 <= 3N-2.
    localparam int CW  = $clog2(3 * N);
    // The normalisation shift never exceeds N-1.
    localparam int SHW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [W2-1:0]    a_q;        // dividend, shifted out MSB first
    logic [N-1:0]     b_q;        // divisor, normalised in place
    logic [W2-1:0]    q_acc_q;    // quotient being built
    logic [N-2:0]     r_acc_q;    // working remainder
    logic [SHW-1:0]   sh_q;       // normalisation shift count
    logic [CW-1:0]    cnt_q;      // remaining division steps minus one

    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [W2-1:0]    q_q;
    logic [N-2:0]     r_q;

    // -------------------------------------------------------------------------
    // One division step. The next dividend bit is appended below the working
    // remainder. If the resulting top coefficient is set, the normalised
    // divisor is subtracted (XOR). Its top bit is known to be 1 and cancels,
    // so only the low N-1 bits take part.
    // -------------------------------------------------------------------------
    logic [N-1:0]     t_d;
    logic             qbit_d;
    logic [N-2:0]     r_step_d;

    assign t_d    = {r_acc_q, a_q[W2-1]};
    assign qbit_d = t_d[N-1];

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_step
        assign r_step_d[gi] = t_d[gi] ^ (qbit_d & b_q[gi]);
    end

    // -------------------------------------------------------------------------
    // Control and datapath state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_acc_q <= '0;
            r_acc_q <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (b_i != '0) begin
                            a_q     <= a_i;
                            b_q     <= b_i;
                            q_acc_q <= '0;
                            r_acc_q <= '0;
                            sh_q    <= '0;
                            state_q <= S_NORM;
                        end else begin
                            // Division by zero: report right away, without
                            // touching the datapath.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            q_q     <= '0;
                            r_q     <= '0;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_NORM: begin
                    if (b_q[N-1]) begin
                        // Feed the whole dividend plus sh zero bits. Those
                        // extra bits multiply the dividend by x^sh, matching
                        // the shift that was applied to the divisor.
                        cnt_q   <= CW'(W2) + CW'(sh_q) - CW'(1);
                        state_q <= S_DIV;
                    end else begin
                        b_q  <= b_q << 1;
                        sh_q <= sh_q + SHW'(1);
                    end
                end

                S_DIV: begin
                    a_q     <= a_q << 1;
                    r_acc_q <= r_step_d;
                    q_acc_q <= {q_acc_q[W2-2:0], qbit_d};
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                S_FIX: begin
                    // The remainder is (a mod b) * x^sh. Its low sh bits are
                    // zero, so shift it back down by sh places.
                    if (sh_q == '0) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        q_q     <= q_acc_q;
                        r_q     <= r_acc_q;
                        state_q <= S_DONE;
                    end else begin
                        r_acc_q <= r_acc_q >> 1;
                        sh_q    <= sh_q - SHW'(1);
                    end
                end

                S_DONE: begin
                    // Any start seen in this cycle is dropped.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign q_o    = q_q;
    assign r_o    = r_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// -----------------------------------------------------------------------------
// tb_gf2_poly_divider
//
// Testbench for gf2_poly_divider. It uses two instances: N=8 for the directed
// vectors, protocol checks and short random runs, and N=571 for full-size
// random divisions.
//
// When a start is accepted, the expected result is pushed onto a queue. It is
// popped and checked when done pulses.
// -----------------------------------------------------------------------------
module tb_gf2_poly_divider;

    localparam int NS = 8;
    localparam int NB = 571;
    localparam int WB = 2 * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // N = 8 instance
    logic              start8 = 1'b0;
    logic [2*NS-1:0]   a8 = '0;
    logic [NS-1:0]     b8 = '0;
    logic              busy8, done8, err8;
    logic [2*NS-1:0]   q8;
    logic [NS-2:0]     r8;

    // N = 571 instance
    logic              startb = 1'b0;
    logic [WB-1:0]     ab = '0;
    logic [NB-1:0]     bb = '0;
    logic              busyb, doneb, errb;
    logic [WB-1:0]     qb;
    logic [NB-2:0]     rb;

    gf2_poly_divider #(.N(NS)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .err_o(err8), .q_o(q8), .r_o(r8)
    );

    gf2_poly_divider #(.N(NB)) u_dutb (
        .clk(clk), .rst(rst), .start_i(startb), .a_i(ab), .b_i(bb),
        .busy_o(busyb), .done_o(doneb), .err_o(errb), .q_o(qb), .r_o(rb)
    );

    typedef struct {
        logic [WB-1:0] a;
        logic [NB-1:0] b;
        logic [WB-1:0] q;
        logic [NB-1:0] r;
        logic          err;
        int            lat;
        int            ts;
    } exp_t;

    exp_t sb8[$];
    exp_t sbb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (low 128 bits)", tag, got[127:0], want[127:0]);
        end
    endtask

    // ---------------------------------------------------------------- models
    function automatic int deg_of(input logic [NB-1:0] b);
        int d = -1;
        for (int i = 0; i < NB; i++) if (b[i]) d = i;
        return d;
    endfunction

    // Plain textbook long division (no normalisation). Only the low n / 2n
    // bits of b / a are taken as meaningful.
    function automatic void model(input int n, input logic [WB-1:0] a, input logic [NB-1:0] b,
                                  output logic [WB-1:0] q, output logic [NB-1:0] r,
                                  output logic err, output int lat);
        int db;
        logic [WB-1:0] w, bw;
        db = -1;
        for (int i = 0; i < n; i++) if (b[i]) db = i;
        q = '0; r = '0; err = 1'b0; lat = 0;
        if (db < 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        w  = a;
        bw = WB'(b);
        for (int i = 2 * n - 1; i >= db; i--) begin
            if (w[i]) begin
                w = w ^ (bw << (i - db));
                q[i - db] = 1'b1;
            end
        end
        r   = w[NB-1:0];
        lat = 2 * n + 3 * (n - 1 - db) + 3;
    endfunction

    function automatic logic [WB-1:0] clmul(input logic [NB-1:0] x, input logic [NB-1:0] y);
        logic [WB-1:0] p = '0;
        for (int j = 0; j < NB; j++) if (y[j]) p = p ^ (WB'(x) << j);
        return p;
    endfunction

    function automatic logic [WB+NB-1:0] mul_qb(input logic [WB-1:0] q, input logic [NB-1:0] b);
        logic [WB+NB-1:0] p = '0;
        for (int j = 0; j < NB; j++) if (b[j]) p = p ^ ((WB+NB)'(q) << j);
        return p;
    endfunction

    function automatic logic [1151:0] rnd_wide();
        logic [1151:0] v;
        for (int k = 0; k < 36; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // -------------------------------------------------------------- monitors
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk_eq("n8_done_expected", WB'(sb8.size() > 0), WB'(1));
            if (sb8.size() > 0) begin
                e = sb8.pop_front();
                chk_eq("n8_q",   WB'(q8),   e.q);
                chk_eq("n8_r",   WB'(r8),   WB'(e.r));
                chk_eq("n8_err", WB'(err8), WB'(e.err));
                chk_eq("n8_lat", WB'(cyc - e.ts + 1), WB'(e.lat));
                $display("n8  a=%04h b=%02h -> q=%04h r=%02h err=%0b lat=%0d",
                         e.a[15:0], e.b[7:0], q8, r8, err8, cyc - e.ts + 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic [WB+NB-1:0] p;
        int db;
        if (doneb) begin
            chk_eq("nb_done_expected", WB'(sbb.size() > 0), WB'(1));
            if (sbb.size() > 0) begin
                e = sbb.pop_front();
                chk_eq("nb_q",   qb,        e.q);
                chk_eq("nb_r",   WB'(rb),   WB'(e.r));
                chk_eq("nb_err", WB'(errb), WB'(e.err));
                chk_eq("nb_lat", WB'(cyc - e.ts + 1), WB'(e.lat));
                db = deg_of(e.b);
                if (db >= 0) begin
                    p = mul_qb(qb, e.b);
                    chk_eq("nb_qb_xor_r", p[WB-1:0] ^ WB'(rb), e.a);
                    chk_eq("nb_prod_hi",  WB'(|p[WB+NB-1:WB]), WB'(0));
                    chk_eq("nb_deg_r",    WB'(|({1'b0, rb} >> db)), WB'(0));
                end
                $display("nb  deg_b=%0d -> q[63:0]=%016h r[63:0]=%016h err=%0b lat=%0d",
                         db, qb[63:0], rb[63:0], errb, cyc - e.ts + 1);
            end
        end
    end

    // --------------------------------------------------------------- drivers
    // Assumes the N=8 unit is idle at the next rising edge.
    task automatic push8(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                         input logic [6:0] r, input logic err, input int lat, input bit poke);
        exp_t e;
        @(posedge clk); #1;
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        e.a = WB'(a); e.b = NB'(b); e.q = WB'(q); e.r = NB'(r);
        e.err = err; e.lat = lat; e.ts = cyc;
        sb8.push_back(e);
        // Inputs changing after acceptance must not matter.
        a8 = 16'($urandom); b8 = 8'($urandom);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 start8 = 1'b1; a8 = 16'h5A5A; b8 = 8'h01;
            @(posedge clk); #1 start8 = 1'b0;
        end
    endtask

    task automatic rand8(input logic [15:0] a, input logic [7:0] b, input bit poke);
        logic [WB-1:0] q; logic [NB-1:0] r; logic err; int lat;
        model(NS, WB'(a), NB'(b), q, r, err, lat);
        push8(a, b, q[15:0], r[6:0], err, lat, poke);
    endtask

    task automatic wait8();
        for (int k = 0; k < 100 && sb8.size() != 0; k++) @(negedge clk);
        chk_eq("n8_drain", WB'(sb8.size()), WB'(0));
        sb8.delete();
    endtask

    task automatic pushb(input logic [WB-1:0] a, input logic [NB-1:0] b, input logic [WB-1:0] q,
                         input logic [NB-1:0] r, input logic err, input int lat);
        exp_t e;
        @(posedge clk); #1;
        ab = a; bb = b; startb = 1'b1;
        @(posedge clk); #1;
        startb = 1'b0;
        e.a = a; e.b = b; e.q = q; e.r = r; e.err = err; e.lat = lat; e.ts = cyc;
        sbb.push_back(e);
        ab = rnd_wide()[WB-1:0]; bb = rnd_wide()[NB-1:0];
    endtask

    task automatic randb(input logic [WB-1:0] a, input logic [NB-1:0] b);
        logic [WB-1:0] q; logic [NB-1:0] r; logic err; int lat;
        model(NB, a, b, q, r, err, lat);
        pushb(a, b, q, r, err, lat);
    endtask

    task automatic waitb();
        for (int k = 0; k < 4000 && sbb.size() != 0; k++) @(negedge clk);
        chk_eq("nb_drain", WB'(sbb.size()), WB'(0));
        sbb.delete();
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        logic [15:0] ra;
        logic [7:0]  rbv;
        logic [NB-1:0] x, y, m;
        logic [WB-1:0] wa;
        int sh;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_busy8", WB'(busy8), WB'(0));
        chk_eq("rst_done8", WB'(done8), WB'(0));
        chk_eq("rst_err8",  WB'(err8),  WB'(0));
        chk_eq("rst_q8",    WB'(q8),    WB'(0));
        chk_eq("rst_r8",    WB'(r8),    WB'(0));
        chk_eq("rst_busyb", WB'(busyb), WB'(0));
        chk_eq("rst_qb",    qb,         WB'(0));

        // Directed vectors, N = 8: a, b, q, r, err, latency
        push8(16'hFFFF, 8'h80, 16'h01FF, 7'h7F, 1'b0, 19, 1'b0); wait8();
        push8(16'hABCD, 8'h01, 16'hABCD, 7'h00, 1'b0, 40, 1'b0); wait8();
        push8(16'h0005, 8'h03, 16'h0003, 7'h00, 1'b0, 37, 1'b0); wait8();
        push8(16'h0008, 8'h0B, 16'h0001, 7'h03, 1'b0, 31, 1'b0); wait8();
        push8(16'h0003, 8'h0B, 16'h0000, 7'h03, 1'b0, 31, 1'b0); wait8();
        push8(16'h1234, 8'h00, 16'h0000, 7'h00, 1'b1,  1, 1'b0); wait8();
        push8(16'h0000, 8'h5B, 16'h0000, 7'h00, 1'b0, 22, 1'b0); wait8();
        push8(16'h0055, 8'h80, 16'h0000, 7'h55, 1'b0, 19, 1'b0); wait8();
        push8(16'hABCD, 8'h01, 16'hABCD, 7'h00, 1'b0, 40, 1'b1); wait8();
        push8(16'h0005, 8'h03, 16'h0003, 7'h00, 1'b0, 37, 1'b1); wait8();

        // Start raised in the DONE cycle is dropped.
        push8(16'hFFFF, 8'h80, 16'h01FF, 7'h7F, 1'b0, 19, 1'b0);
        for (int k = 0; k < 100 && !done8; k++) @(negedge clk);
        start8 = 1'b1; a8 = 16'h1111; b8 = 8'h80;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("n8_start_in_done_busy", WB'(busy8), WB'(0));
        wait8();

        // Reset in the middle of DIV aborts without a done pulse.
        push8(16'h1234, 8'h80, 16'h0024, 7'h34, 1'b0, 19, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb8.delete();
        chk_eq("n8_abort_busy", WB'(busy8), WB'(0));
        chk_eq("n8_abort_done", WB'(done8), WB'(0));
        chk_eq("n8_abort_q",    WB'(q8),    WB'(0));
        chk_eq("n8_abort_r",    WB'(r8),    WB'(0));
        repeat (40) @(negedge clk);
        chk_eq("n8_abort_idle", WB'(busy8), WB'(0));
        push8(16'h0008, 8'h0B, 16'h0001, 7'h03, 1'b0, 31, 1'b0); wait8();

        // Random N = 8
        for (int k = 0; k < 30; k++) begin
            ra  = 16'($urandom);
            rbv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rand8(ra, rbv, (k % 5 == 0) && (rbv != 8'h00));
            wait8();
        end

        // N = 571: products of two 571-bit polynomials divided by one factor.
        for (int k = 0; k < 4; k++) begin
            x = rnd_wide()[NB-1:0];
            y = rnd_wide()[NB-1:0];
            sh = (k == 3) ? 9 : 0;
            m = {NB{1'b1}} >> sh;
            y = y & m;
            y[NB-1-sh] = 1'b1;
            pushb(clmul(x, y), y, WB'(x), '0, 1'b0, WB + 3 * sh + 3);
            waitb();
        end

        // N = 571 random dividends and divisors of varying degree.
        for (int k = 0; k < 6; k++) begin
            sh = $urandom_range(0, 15);
            y  = rnd_wide()[NB-1:0];
            m  = {NB{1'b1}} >> sh;
            y  = y & m;
            y[NB-1-sh] = 1'b1;
            randb(rnd_wide()[WB-1:0], y);
            waitb();
        end

        // N = 571 edge cases: b = 1, b = 0, deg a < deg b
        wa = rnd_wide()[WB-1:0];
        pushb(wa, NB'(1), wa, '0, 1'b0, WB + 3 * (NB - 1) + 3);
        waitb();
        pushb(rnd_wide()[WB-1:0], '0, '0, '0, 1'b1, 1);
        waitb();
        wa = '0;
        wa[NB-2:0] = rnd_wide()[NB-2:0];
        y = rnd_wide()[NB-1:0];
        y[NB-1] = 1'b1;
        pushb(wa, y, '0, wa[NB-1:0], 1'b0, WB + 3);
        waitb();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gf2_poly_divider.md
GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

Interface
REQ-001 Parameter: N, default 571, divisor width in bits; dividend width is 2N, matching the two_way_karatsuba product width 1142.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  2N  dividend polynomial over GF(2), bit i = coefficient of x^i; sampled on accepted start.
REQ-006 b  input  N  divisor polynomial over GF(2); sampled on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when q, r, err are valid.
REQ-009 err  output  1  divide-by-zero flag, valid with done.
REQ-010 q  output  2N  quotient, a div b over GF(2).
REQ-011 r  output  N-1  remainder, a mod b over GF(2); deg r < deg b.

Function
REQ-012 All arithmetic is carry-less GF(2): addition and subtraction are XOR; q*b XOR r == a SHALL hold for every b != 0.
REQ-013 States: IDLE, NORM, DIV, FIX, DONE; outputs registered.
REQ-014 IDLE: start=1 with b!=0 -> capture A=a, B=b, clear remainder register R (N-1 bits), quotient register Q (2N bits), shift count sh=0 -> NORM; start=1 with b==0 -> DONE with err=1, q=0, r=0.
REQ-015 NORM, each cycle: B[N-1]==1 -> DIV with step count 2N+sh; else B <= B<<1, sh <= sh+1; duration sh+1 cycles.
REQ-016 DIV, each cycle: bit=A[2N-1]; A <= A<<1 (zero fill); T={R,bit} (N bits); T[N-1]==1 -> R <= T[N-2:0] XOR B[N-2:0], qbit=1; else R <= T[N-2:0], qbit=0; Q <= {Q[2N-2:0],qbit}; duration 2N+sh cycles, then FIX.
REQ-017 FIX, each cycle: sh==0 -> DONE; else R <= R>>1, sh <= sh-1; duration sh+1 cycles (sh as left by NORM).
REQ-018 DONE: done=1 for exactly one cycle, q<=Q, r<=R, err as determined; next state IDLE.
REQ-019 Latency: start accepted at cycle T -> done at T+2N+3*sh+3, sh = N-1-deg(b); divide-by-zero -> done at T+1.
REQ-020 q, r, err hold their values from DONE until the next DONE or reset.
REQ-021 start while busy=1 is ignored, no queueing; start in the DONE cycle is ignored.
REQ-022 Changes on a, b after acceptance do not affect the running operation.
REQ-023 deg(a) < deg(b) -> q=0, r=a; a=0 -> q=0, r=0; b=1 -> q=a, r=0.

Reset
REQ-024 rst=1 -> next edge: state IDLE, busy=0, done=0, err=0, q=0, r=0, A=B=Q=R=0, sh=0.
REQ-025 rst has priority over start and aborts any operation mid-NORM/DIV/FIX; no done pulse for the aborted operation.

Verification (N=8 unless stated)
REQ-026 b=8'h80, a=16'hFFFF -> q=16'h01FF, r=7'h7F, err=0, done 19 cycles after start.
REQ-027 b=8'h01, a=16'hABCD -> q=16'hABCD, r=7'h00, done 40 cycles after start; b=8'h03, a=16'h0005 -> q=16'h0003, r=0, done after 37 cycles.
REQ-028 b=8'h0B, a=16'h0008 -> q=16'h0001, r=7'h03; b=8'h0B, a=16'h0003 -> q=0, r=7'h03.
REQ-029 b=8'h00, any a -> done 1 cycle after start, err=1, q=0, r=0; start pulsed during busy -> no effect on result or latency.
REQ-030 rst asserted mid-DIV -> busy=0 and q=r=0 next cycle, no done; new start then completes normally.
REQ-031 N=571, 1000 random (a, b!=0) including a from two_way_karatsuba outputs -> q*b XOR r == a, deg r < deg b, latency per REQ-019.
